// File: rtl/mat_inv_feeder.sv
// Matrix-inverse feeder: accumulates the moment sums n, sum(x) and sum(x^2)
// over a batch of regressor samples, then holds them with a start level
// until the inverse block answers with inv_valid or the wait times out.
module mat_inv_feeder #(
    parameter int X_W     = 8,
    parameter int LEN_W   = 12,
    parameter int SIG0_W  = 21,
    parameter int SIG1_W  = 20,
    parameter int SIG2_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [LEN_W-1:0]  batch_len,
    output logic              busy,
    input  logic              x_valid,
    input  logic [X_W-1:0]    x_data,
    output logic              x_ready,
    output logic              start,
    output logic [SIG0_W-1:0] sig0,
    output logic [SIG1_W-1:0] sig1,
    output logic [SIG2_W-1:0] sig2,
    input  logic              inv_valid,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    // Wait counter spans 0..TIMEOUT-1; keep at least one bit for TIMEOUT=1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [TW-1:0]    wcnt;
    logic             take;

    // Full-width square, zero-extended into the sum-of-squares width.
    // The accumulator is wide enough for a full batch, so no saturation.
    function automatic logic [SIG2_W-1:0] square_ext(input logic [X_W-1:0] x);
        logic [2*X_W-1:0] xe;
        xe = {{X_W{1'b0}}, x};
        return SIG2_W'(xe * xe);
    endfunction

    assign x_ready = (state == S_ACCUM);
    assign start   = (state == S_SEND) || (state == S_WAIT);
    assign busy    = (state != S_IDLE);
    assign take    = x_valid && x_ready;

    // Control FSM, moment accumulators and completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            len_q <= '0;
            cnt   <= '0;
            wcnt  <= '0;
            sig0  <= '0;
            sig1  <= '0;
            sig2  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (batch_len != '0) begin
                            len_q <= batch_len;
                            cnt   <= '0;
                            sig0  <= '0;
                            sig1  <= '0;
                            sig2  <= '0;
                            state <= S_ACCUM;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (take) begin
                        sig0 <= sig0 + SIG0_W'(1);
                        sig1 <= sig1 + SIG1_W'(x_data);
                        sig2 <= sig2 + square_ext(x_data);
                        cnt  <= cnt + LEN_W'(1);
                        // Last sample: leave ACCUM so x_ready drops next cycle.
                        if (cnt == len_q - LEN_W'(1)) begin
                            state <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    wcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // inv_valid takes priority over a timeout in the same cycle.
                    if (inv_valid) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (wcnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wcnt <= wcnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_inv_feeder.sv
// Bench for mat_inv_feeder: directed and randomized batches compared
// against moment sums computed directly from the list of sent samples.
module tb_mat_inv_feeder;

    localparam int X_W     = 8;
    localparam int LEN_W   = 12;
    localparam int SIG0_W  = 21;
    localparam int SIG1_W  = 20;
    localparam int SIG2_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic [LEN_W-1:0]  batch_len;
    logic              busy;
    logic              x_valid;
    logic [X_W-1:0]    x_data;
    logic              x_ready;
    logic              start;
    logic [SIG0_W-1:0] sig0;
    logic [SIG1_W-1:0] sig1;
    logic [SIG2_W-1:0] sig2;
    logic              inv_valid;
    logic              done;
    logic              err;

    mat_inv_feeder #(
        .X_W(X_W), .LEN_W(LEN_W), .SIG0_W(SIG0_W), .SIG1_W(SIG1_W),
        .SIG2_W(SIG2_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .batch_len(batch_len),
        .busy(busy), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
        .start(start), .sig0(sig0), .sig1(sig1), .sig2(sig2),
        .inv_valid(inv_valid), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Event counters, written only by this monitor (pre-edge values).
    int hs_cnt    = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int start_cyc = 0;

    // Samples sent in the current batch: the reference model input.
    int xs[$];

    always @(posedge clk) begin
        if (x_valid && x_ready) hs_cnt++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (start) start_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Moment sums straight from their definition.
    task automatic check_sums(input string tag);
        longint e0, e1, e2;
        e0 = xs.size();
        e1 = 0;
        e2 = 0;
        foreach (xs[i]) begin
            e1 += xs[i];
            e2 += longint'(xs[i]) * longint'(xs[i]);
        end
        check({tag, "_sig0"}, sig0, e0);
        check({tag, "_sig1"}, sig1, e1);
        check({tag, "_sig2"}, sig2, e2);
    endtask

    task automatic do_cmd(input int len);
        cmd_valid = 1'b1;
        batch_len = LEN_W'(len);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Sends one sample after some idle gap cycles; leaves x_valid high.
    task automatic feed_one(input int v, input int gaps);
        repeat (gaps) begin
            x_valid = 1'b0;
            x_data  = X_W'($urandom);
            tick();
        end
        x_valid = 1'b1;
        x_data  = X_W'(v);
        xs.push_back(v);
        tick();
    endtask

    // Called in SEND: holds n cycles with start high, then answers inv_valid.
    // With stale set, inv_valid is high during the SEND cycle only.
    task automatic ack_after(input int n, input bit stale, input string tag);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < n; i++) begin
            inv_valid = stale && (i == 0);
            check({tag, "_start_hold"}, start, 1);
            check_sums({tag, "_hold"});
            tick();
        end
        inv_valid = 1'b1;
        tick();
        inv_valid = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_start_fall"}, start, 0);
        check({tag, "_no_err"}, err, 0);
        tick();
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_err_none"}, err_cnt - e0, 0);
    endtask

    initial begin
        int h0, d0, e0, s0, nt, len;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        batch_len = '0;
        x_valid   = 1'b0;
        x_data    = '0;
        inv_valid = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_x_ready", x_ready, 0);
        check("rst_start", start, 0);
        check("rst_sig0", sig0, 0);
        check("rst_sig1", sig1, 0);
        check("rst_sig2", sig2, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Basic batch 1,2,3.
        xs.delete();
        s0 = start_cyc;
        do_cmd(3);
        check("basic_busy", busy, 1);
        check("basic_x_ready", x_ready, 1);
        feed_one(1, 0);
        feed_one(2, 0);
        feed_one(3, 0);
        x_valid = 1'b0;
        check("basic_x_ready_drop", x_ready, 0);
        check("basic_start", start, 1);
        check("basic_sig0", sig0, 3);
        check("basic_sig1", sig1, 6);
        check("basic_sig2", sig2, 14);
        ack_after(4, 1'b0, "basic");
        check("basic_start_cycles", start_cyc - s0, 5);

        // Maximum batch of 4095 samples at 255, x_valid left high afterwards.
        xs.delete();
        h0 = hs_cnt;
        do_cmd(4095);
        for (int i = 0; i < 4095; i++) feed_one(255, 0);
        check("max_sig0", sig0, 4095);
        check("max_sig1", sig1, 1044225);
        check("max_sig2", sig2, 266277375);
        tick();
        tick();
        check("max_handshakes", hs_cnt - h0, 4095);
        check("max_x_ready", x_ready, 0);
        x_valid = 1'b0;
        ack_after(2, 1'b0, "max");

        // Stalled stream: 7, three gap cycles, 9, then an extra offered sample.
        xs.delete();
        h0 = hs_cnt;
        do_cmd(2);
        feed_one(7, 0);
        feed_one(9, 3);
        x_data = 8'd11;
        tick();
        x_valid = 1'b0;
        check("stall_handshakes", hs_cnt - h0, 2);
        check("stall_sig1", sig1, 16);
        check("stall_sig2", sig2, 130);
        ack_after(2, 1'b0, "stall");

        // Zero-length command.
        e0 = err_cnt;
        do_cmd(0);
        check("zero_err", err, 1);
        check("zero_busy", busy, 0);
        check("zero_x_ready", x_ready, 0);
        tick();
        check("zero_err_clear", err, 0);
        check("zero_err_once", err_cnt - e0, 1);

        // New command during ACCUM must be ignored.
        xs.delete();
        do_cmd(3);
        cmd_valid = 1'b1;
        batch_len = LEN_W'(1);
        feed_one(10, 0);
        feed_one(20, 0);
        cmd_valid = 1'b0;
        check("overlap_still_accum", x_ready, 1);
        check("overlap_no_start", start, 0);
        feed_one(30, 0);
        x_valid = 1'b0;
        check("overlap_start", start, 1);
        check_sums("overlap");
        ack_after(1, 1'b0, "overlap");

        // Random batches, with a stale inv_valid pulse in SEND.
        repeat (4) begin
            xs.delete();
            len = $urandom_range(1, 12);
            do_cmd(len);
            for (int i = 0; i < len; i++) feed_one($urandom_range(0, 255), $urandom_range(0, 2));
            x_valid = 1'b0;
            check_sums("rand");
            ack_after($urandom_range(2, 6), 1'b1, "rand");
        end

        // inv_valid on the last permitted WAIT cycle wins over timeout.
        xs.delete();
        do_cmd(1);
        feed_one($urandom_range(0, 255), 0);
        x_valid = 1'b0;
        ack_after(TIMEOUT, 1'b0, "edge");

        // Timeout: start high for SEND plus TIMEOUT WAIT cycles, then err.
        xs.delete();
        s0 = start_cyc;
        e0 = err_cnt;
        d0 = done_cnt;
        do_cmd(2);
        feed_one($urandom_range(0, 255), 0);
        feed_one($urandom_range(0, 255), 0);
        x_valid = 1'b0;
        nt = 0;
        for (int i = 0; i < 4 * TIMEOUT; i++) begin
            tick();
            nt++;
            if (err) break;
        end
        check("to_cycles", nt, TIMEOUT + 1);
        check("to_err", err, 1);
        check("to_start", start, 0);
        check("to_busy", busy, 0);
        check("to_start_cycles", start_cyc - s0, TIMEOUT + 1);
        inv_valid = 1'b1;
        tick();
        tick();
        tick();
        inv_valid = 1'b0;
        check("to_late_no_done", done_cnt - d0, 0);
        check("to_err_once", err_cnt - e0, 1);
        check("to_idle", busy, 0);

        // Reset during WAIT aborts silently.
        xs.delete();
        do_cmd(1);
        feed_one($urandom_range(1, 255), 0);
        x_valid = 1'b0;
        tick();
        tick();
        check("rstw_start_before", start, 1);
        d0 = done_cnt;
        e0 = err_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_start", start, 0);
        check("rstw_sig0", sig0, 0);
        check("rstw_sig1", sig1, 0);
        check("rstw_sig2", sig2, 0);
        check("rstw_busy", busy, 0);
        check("rstw_done", done, 0);
        check("rstw_err", err, 0);
        tick();
        check("rstw_no_done", done_cnt - d0, 0);
        check("rstw_no_err", err_cnt - e0, 0);
        xs.delete();
        do_cmd(1);
        feed_one(5, 0);
        x_valid = 1'b0;
        check("after_rst_sig0", sig0, 1);
        check("after_rst_sig1", sig1, 5);
        check("after_rst_sig2", sig2, 25);
        ack_after(2, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
